sfp_led_mgr: RTL

//  Parametrised per-port LED/status manager for the SFP cage board. Runs a
//  one-hot power-on sweep across all TX/RX LEDs for STARTUP_CYCLES, then

---
 rtl/sfp_led_mgr.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sfp_led_mgr.sv
// -----------------------------------------------------------------------------
// sfp_led_mgr
// Per-port LED and status manager for the SFP cage board.
//
// After reset release the block runs a one-hot sweep across every TX/RX LED
// for STARTUP_CYCLES clocks. It then drives each LED from a 2-bit host mode:
//   00 off, 01 on, 10 blink, 11 auto (follows the synchronised SFP status).
// The raw SFP status pins are also synchronised here for the I2C register file.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   mode_tx       TX LED mode, port p = [2p+1:2p]
//   mode_rx       RX LED mode, port p = [2p+1:2p]
//   sfp_mod_abs   raw module-absent pins (asynchronous)
//   sfp_rx_los    raw loss-of-signal pins (asynchronous)
//   sfp_tx_fault  raw TX-fault pins (asynchronous)
//   led_tx        registered TX LED drive
//   led_rx        registered RX LED drive
//   st_mod_abs    synchronised sfp_mod_abs
//   st_rx_los     synchronised sfp_rx_los
//   st_tx_fault   synchronised sfp_tx_fault
//   startup_done  high once the sweep has finished; sticky until reset
// -----------------------------------------------------------------------------
module sfp_led_mgr #(
    parameter int NUM_PORTS      = 6,
    parameter int STARTUP_CYCLES = 144000000,
    parameter int SWEEP_CYCLES   = 12000000,
    parameter int BLINK_CYCLES   = 6000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NUM_PORTS-1:0] mode_tx,
    input  logic [2*NUM_PORTS-1:0] mode_rx,
    input  logic [NUM_PORTS-1:0]   sfp_mod_abs,
    input  logic [NUM_PORTS-1:0]   sfp_rx_los,
    input  logic [NUM_PORTS-1:0]   sfp_tx_fault,
    output logic [NUM_PORTS-1:0]   led_tx,
    output logic [NUM_PORTS-1:0]   led_rx,
    output logic [NUM_PORTS-1:0]   st_mod_abs,
    output logic [NUM_PORTS-1:0]   st_rx_los,
    output logic [NUM_PORTS-1:0]   st_tx_fault,
    output logic                   startup_done
);

    localparam int NUM_LEDS = 2 * NUM_PORTS;

    // Counter widths, never narrower than one bit.
    localparam int SC_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int SW_W = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int SP_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [SC_W-1:0] SC_LAST = SC_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic [SW_W-1:0] SW_LAST = SW_W'(SWEEP_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(NUM_LEDS - 1);

    typedef enum logic {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [SC_W-1:0]     startup_cnt;
    logic [SW_W-1:0]     step_cnt;
    logic [SP_W-1:0]     sweep_pos;
    logic [BL_W-1:0]     blink_cnt;
    logic                blink_phase;
    logic                done_next;
    logic [NUM_LEDS-1:0] sweep_vec;
    logic [NUM_LEDS-1:0] run_vec;
    logic [NUM_LEDS-1:0] led_next;

    // ------------------------------------------------------------------
    // Status synchronisers: one flop chain per bit, output is last stage.
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] abs_sync [SYNC_STAGES];
    logic [NUM_PORTS-1:0] los_sync [SYNC_STAGES];
    logic [NUM_PORTS-1:0] flt_sync [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                abs_sync[i] <= '0;
                los_sync[i] <= '0;
                flt_sync[i] <= '0;
            end
        end else begin
            abs_sync[0] <= sfp_mod_abs;
            los_sync[0] <= sfp_rx_los;
            flt_sync[0] <= sfp_tx_fault;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                abs_sync[i] <= abs_sync[i-1];
                los_sync[i] <= los_sync[i-1];
                flt_sync[i] <= flt_sync[i-1];
            end
        end
    end

    assign st_mod_abs  = abs_sync[SYNC_STAGES-1];
    assign st_rx_los   = los_sync[SYNC_STAGES-1];
    assign st_tx_fault = flt_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Free-running blink generator, shared by every LED so they stay in phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sweep counters; they only advance while the sweep is running.
    // startup_cnt holds at its last value once RUN is reached.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startup_cnt <= '0;
            step_cnt    <= '0;
            sweep_pos   <= '0;
        end else if (state == ST_STARTUP) begin
            if (startup_cnt != SC_LAST) begin
                startup_cnt <= startup_cnt + SC_W'(1);
            end
            if (step_cnt == SW_LAST) begin
                step_cnt  <= '0;
                sweep_pos <= (sweep_pos == SP_LAST) ? '0 : sweep_pos + SP_W'(1);
            end else begin
                step_cnt <= step_cnt + SW_W'(1);
            end
        end
    end

    // Bit i of the {led_rx, led_tx} vector is lit when sweep_pos == i.
    always_comb begin
        sweep_vec = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            sweep_vec[i] = (sweep_pos == SP_W'(i));
        end
    end

    // Mode-driven LED values; low half is TX, high half is RX.
    always_comb begin
        run_vec = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            case (mode_tx[2*p +: 2])
                2'b00:   run_vec[p] = 1'b0;
                2'b01:   run_vec[p] = 1'b1;
                2'b10:   run_vec[p] = blink_phase;
                default: run_vec[p] = st_mod_abs[p] ? 1'b0 :
                                      (st_tx_fault[p] ? blink_phase : 1'b1);
            endcase
            case (mode_rx[2*p +: 2])
                2'b00:   run_vec[NUM_PORTS+p] = 1'b0;
                2'b01:   run_vec[NUM_PORTS+p] = 1'b1;
                2'b10:   run_vec[NUM_PORTS+p] = blink_phase;
                default: run_vec[NUM_PORTS+p] = st_mod_abs[p] ? 1'b0 : ~st_rx_los[p];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: STARTUP -> RUN, leaves RUN only through reset.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        led_next   = '0;
        case (state)
            ST_STARTUP: begin
                led_next = sweep_vec;
                if (startup_cnt == SC_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                led_next = run_vec;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        done_next = startup_done | (state_next == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // With no sweep configured the block comes out of reset in RUN.
            if (STARTUP_CYCLES == 0) begin
                state <= ST_RUN;
            end else begin
                state <= ST_STARTUP;
            end
            led_tx       <= '0;
            led_rx       <= '0;
            startup_done <= 1'b0;
        end else begin
            state        <= state_next;
            led_tx       <= led_next[NUM_PORTS-1:0];
            led_rx       <= led_next[NUM_LEDS-1:NUM_PORTS];
            startup_done <= done_next;
        end
    end

endmodule
